mic_bin_aligner: RTL
====================

// Module: mic_bin_aligner
// PURPOSE
//  Producer side of the direction-calculator input interface. Accepts one stream per mic
//  (index 0 = central, 1..PERIPHERAL_MICS = peripheral) of packed per-bin FFT words
//  {phase[DATA_WIDTH-1:DATA_WIDTH/2] 2Q13, magnitude[DATA_WIDTH/2-1:0]}. Buffers each
//  stream, then emits one bin-aligned tuple per handshake to the direction calculator.
//  Sits between the per-mic CORDIC magnitude/phase stages and direction calculation.
// PARAMETERS
//  PERIPHERAL_MICS  3     number of peripheral mics; total streams NM = PERIPHERAL_MICS+1
//  DATA_WIDTH       32    packed word width; must be even
//  FFT_SIZE         1024  bins per frame; power of two, >= 4
//  FIFO_DEPTH       16    words buffered per stream; power of two, >= 2
// PORTS
//  clk_in             in   1                   system clock
//  rst_in             in   1                   reset; synchronous, active-low
//  mic_tdata_in[NM]   in   DATA_WIDTH each     packed {phase, mag} word per stream
//  mic_tvalid_in[NM]  in   1 each              word valid
//  mic_tlast_in[NM]   in   1 each              last bin of frame
//  mic_tready_out[NM] out  1 each              stream can accept
//  central_mic_out    out  DATA_WIDTH          stream 0 word of current bin
//  peripheral_mics_out[PERIPHERAL_MICS] out DATA_WIDTH each  streams 1..NM-1, same bin
//  bin_index_out      out  $clog2(FFT_SIZE)    bin number of current tuple
//  valid_out          out  1                   tuple valid
//  last_out           out  1                   tuple is bin FFT_SIZE-1
//  ready_in           in   1                   downstream accepts tuple
//  desync_out         out  1                   1-cycle pulse on framing error
// BEHAVIOUR
//  - Reset (rst_in==0 at posedge): all FIFOs emptied; valid_out, last_out, desync_out,
//    bin_index_out, data outputs = 0; mic_tready_out = 0; state = ALIGN. Mid-operation reset
//    discards all buffered and in-flight data; no tuple is emitted after it.
//  - Input: per-stream FIFO, word written on posedge with tvalid&&tready.
//    mic_tready_out[k] = (FIFO k not full) && rst_in, registered-free (from counts).
//  - Output register: loads when (!valid_out || ready_in) && all NM FIFOs non-empty && state==ALIGN;
//    pops one word from every FIFO in the same cycle. Word accepted at posedge N may
//    appear with valid_out=1 after posedge N+1 (min latency 1 cycle, FIFO empty).
//  - Handshake: while valid_out && !ready_in all outputs hold stable. valid_out drops
//    after ready_in handshake if no new load occurs. Back-to-back 1 tuple/cycle.
//  - bin_index_out: counter of loaded tuples, 0..FFT_SIZE-1, wraps to 0 after last.
//    last_out = (bin_index_out == FFT_SIZE-1).
//  - States: ALIGN, RESYNC.
//    ALIGN: on load, stored tlast flags checked. Error if flags differ across streams or
//    any flag != (counter == FFT_SIZE-1). On error: tuple is NOT loaded, desync_out pulses
//    1 cycle, valid_out->0, go RESYNC. Words in the popped set with tlast=1 count as done.
//    RESYNC: each stream not yet done drains (pops) one word/cycle when non-empty until a
//    tlast word is popped; tready still follows FIFO fullness. When all NM streams done:
//    counter = 0, return ALIGN next cycle.
//  - Simultaneous write and pop on same FIFO: both occur; count unchanged; full FIFO
//    with pop this cycle still shows tready=0 (no bypass).
//  - No arithmetic on data; words passed bit-exact. Phase wrap is downstream's job.
// TESTING
//  1 Reset: hold rst_in=0 3 cycles with tvalid=1 -> tready=0, valid_out=0, bin_index_out=0.
//  2 Aligned frame FFT_SIZE=8, all streams send words 0x0001_0000+bin, ready_in=1 ->
//    8 tuples, bin 0..7, last_out only at bin 7, desync_out never high.
//  3 Skew: stream 2 delayed 5 cycles -> no valid_out until stream 2 data arrives; tuples
//    still bin-aligned, values match per-bin stimulus.
//  4 Backpressure: ready_in=0 for 20 cycles, FIFO_DEPTH=16 -> tready drops after 16(+1
//    output reg) words, outputs stable, no data loss after ready_in returns.
//  5 Framing error: stream 1 asserts tlast at bin 5 of 8 -> desync_out 1-cycle pulse,
//    RESYNC drains to each stream's tlast, next frame restarts at bin_index_out=0.
//  6 Reset mid-frame at bin 3 -> all outputs 0 next cycle; next frame starts at bin 0.

Source files
------------

// File: rtl/mic_bin_aligner_if.sv
// rtl/mic_bin_aligner_if.sv - per-mic input streams and bin-aligned tuple output bundle
`timescale 1ns/1ps
// Groups the NM mic streams (index 0 = central) and the tuple handshake toward the
// direction calculator.
//   master : the aligner (consumes mic streams, produces tuples)
//   slave  : the environment (mic sources plus direction calculator)
interface mic_bin_aligner_if #(
    parameter int PERIPHERAL_MICS = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int FFT_SIZE        = 1024
);
    localparam int NM    = PERIPHERAL_MICS + 1;
    localparam int BIN_W = $clog2(FFT_SIZE);

    logic [NM-1:0][DATA_WIDTH-1:0]              mic_tdata_in;
    logic [NM-1:0]                              mic_tvalid_in;
    logic [NM-1:0]                              mic_tlast_in;
    logic [NM-1:0]                              mic_tready_out;
    logic [DATA_WIDTH-1:0]                      central_mic_out;
    logic [PERIPHERAL_MICS-1:0][DATA_WIDTH-1:0] peripheral_mics_out;
    logic [BIN_W-1:0]                           bin_index_out;
    logic                                       valid_out;
    logic                                       last_out;
    logic                                       ready_in;
    logic                                       desync_out;

    modport master (
        input  mic_tdata_in, mic_tvalid_in, mic_tlast_in, ready_in,
        output mic_tready_out, central_mic_out, peripheral_mics_out,
               bin_index_out, valid_out, last_out, desync_out
    );

    modport slave (
        output mic_tdata_in, mic_tvalid_in, mic_tlast_in, ready_in,
        input  mic_tready_out, central_mic_out, peripheral_mics_out,
               bin_index_out, valid_out, last_out, desync_out
    );
endinterface

// File: rtl/mic_bin_aligner.sv
// rtl/mic_bin_aligner.sv - buffers per-mic FFT bin streams and emits bin-aligned tuples
`timescale 1ns/1ps
// Ports:
//   clk_in  : system clock
//   rst_in  : synchronous active-low reset
//   bus     : mic_bin_aligner_if.master -- NM input streams {phase, mag} with
//             tvalid/tready/tlast, one tuple output (central + peripherals, bin index,
//             last) with valid_out/ready_in, and a one-cycle desync_out framing-error pulse.
module mic_bin_aligner #(
    parameter int PERIPHERAL_MICS = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int FFT_SIZE        = 1024,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mic_bin_aligner_if.master bus
);
    localparam int NM     = PERIPHERAL_MICS + 1;
    localparam int BIN_W  = $clog2(FFT_SIZE);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = DATA_WIDTH + 1;   // {tlast, tdata}

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE - 1);

    typedef enum logic {ST_ALIGN, ST_RESYNC} state_t;

    // FIFO storage and bookkeeping
    logic [NM-1:0][FIFO_DEPTH-1:0][WORD_W-1:0] mem_q, mem_d;
    logic [NM-1:0][PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [NM-1:0][PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [NM-1:0][CNT_W-1:0]                  count_q, count_d;

    // Control and output registers
    state_t                        state_q, state_d;
    logic [NM-1:0]                 done_q, done_d;
    logic [BIN_W-1:0]              bin_cnt_q, bin_cnt_d;   // bin number of next tuple to load
    logic [BIN_W-1:0]              bin_idx_q, bin_idx_d;
    logic                          valid_q, valid_d;
    logic                          last_q, last_d;
    logic                          desync_q, desync_d;
    logic [NM-1:0][DATA_WIDTH-1:0] data_q, data_d;

    logic [NM-1:0]                 not_empty;
    logic [NM-1:0]                 push;
    logic [NM-1:0]                 pop;
    logic [NM-1:0]                 tready;
    logic [NM-1:0]                 head_last;
    logic [NM-1:0][DATA_WIDTH-1:0] head_data;
    logic                          frame_err;

    // Ready comes straight from the occupancy count: a full FIFO refuses even when it
    // is being popped in the same cycle.
    always_comb begin
        for (int k = 0; k < NM; k++) begin
            not_empty[k] = (count_q[k] != '0);
            tready[k]    = (count_q[k] != FULL_CNT) && rst_in;
            push[k]      = bus.mic_tvalid_in[k] && tready[k];
            head_data[k] = mem_q[k][rd_ptr_q[k]][DATA_WIDTH-1:0];
            head_last[k] = mem_q[k][rd_ptr_q[k]][DATA_WIDTH];
        end
    end

    // Alignment / resync control
    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        bin_cnt_d = bin_cnt_q;
        bin_idx_d = bin_idx_q;
        valid_d   = valid_q;
        last_d    = last_q;
        desync_d  = 1'b0;
        data_d    = data_q;
        pop       = '0;
        frame_err = 1'b0;

        case (state_q)
            ST_ALIGN: begin
                if ((!valid_q || bus.ready_in) && (&not_empty)) begin
                    pop = '1;
                    // Every stream must agree on tlast, and tlast must sit exactly on
                    // the final bin of the frame.
                    if (bin_cnt_q == LAST_BIN) begin
                        frame_err = !(&head_last);
                    end else begin
                        frame_err = |head_last;
                    end
                    if (frame_err) begin
                        valid_d  = 1'b0;
                        desync_d = 1'b1;
                        done_d   = head_last;
                        state_d  = ST_RESYNC;
                    end else begin
                        valid_d   = 1'b1;
                        data_d    = head_data;
                        bin_idx_d = bin_cnt_q;
                        last_d    = (bin_cnt_q == LAST_BIN);
                        bin_cnt_d = bin_cnt_q + BIN_W'(1);   // wraps after the last bin
                    end
                end else if (bus.ready_in) begin
                    valid_d = 1'b0;
                end
            end
            ST_RESYNC: begin
                valid_d = 1'b0;
                if (&done_q) begin
                    done_d    = '0;
                    bin_cnt_d = '0;
                    state_d   = ST_ALIGN;
                end else begin
                    // Streams that have not yet reached their tlast discard words.
                    pop    = not_empty & ~done_q;
                    done_d = done_q | (pop & head_last);
                end
            end
            default: state_d = ST_ALIGN;
        endcase
    end

    // FIFO pointer / count / storage updates
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int k = 0; k < NM; k++) begin
            if (push[k]) begin
                mem_d[k][wr_ptr_q[k]] = {bus.mic_tlast_in[k], bus.mic_tdata_in[k]};
                wr_ptr_d[k]           = wr_ptr_q[k] + PTR_W'(1);
            end
            if (pop[k]) begin
                rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
            end
            case ({push[k], pop[k]})
                2'b10:   count_d[k] = count_q[k] + CNT_W'(1);
                2'b01:   count_d[k] = count_q[k] - CNT_W'(1);
                default: count_d[k] = count_q[k];
            endcase
        end
    end

    // Storage needs no reset: emptiness is tracked by the counts alone.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_ALIGN;
            done_q    <= '0;
            bin_cnt_q <= '0;
            bin_idx_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            desync_q  <= 1'b0;
            data_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            done_q    <= done_d;
            bin_cnt_q <= bin_cnt_d;
            bin_idx_q <= bin_idx_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            desync_q  <= desync_d;
            data_q    <= data_d;
        end
    end

    assign bus.mic_tready_out      = tready;
    assign bus.central_mic_out     = data_q[0];
    assign bus.peripheral_mics_out = data_q[NM-1:1];
    assign bus.bin_index_out       = bin_idx_q;
    assign bus.valid_out           = valid_q;
    assign bus.last_out            = last_q;
    assign bus.desync_out          = desync_q;
endmodule
